// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
// Elaboration-time parameter check lives here so every user validates the same ranges.
package hazard_pkg;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_MULTI = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic pc_enable;
    logic if_id_enable;
    logic if_id_flush;
    logic pipeline_stall;
    logic ex_hold;
  } hz_out_t;

  localparam logic RUN_PC_ENABLE      = 1'b1;
  localparam logic RUN_IF_ID_ENABLE   = 1'b1;
  localparam logic RUN_IF_ID_FLUSH    = 1'b0;
  localparam logic RUN_PIPELINE_STALL = 1'b1;
  localparam logic RUN_EX_HOLD        = 1'b0;

  localparam hz_out_t HZ_RUN_OUT = '{
    pc_enable:      RUN_PC_ENABLE,
    if_id_enable:   RUN_IF_ID_ENABLE,
    if_id_flush:    RUN_IF_ID_FLUSH,
    pipeline_stall: RUN_PIPELINE_STALL,
    ex_hold:        RUN_EX_HOLD
  };

  localparam int HZ_CNT_BITS = 4;

  function automatic bit hz_params_ok(int mulLat, int loadLat, int cntW);
    return (mulLat >= 2) && (mulLat <= 16) &&
           (loadLat >= 1) && (loadLat <= 2) &&
           (cntW >= 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Register dependency detector: flags a producer rd that one of the decode sources really reads.
// x0 is hardwired to zero, so a match on register 0 is never a hazard.
module hazard_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  output logic              hit_o
);

  logic rdNonZero;
  logic rs1Hit;
  logic rs2Hit;

  assign rdNonZero = (rd_i != '0);
  assign rs1Hit    = rs1_used_i && (rs1_i == rd_i);
  assign rs2Hit    = rs2_used_i && (rs2_i == rd_i);
  assign hit_o     = rdNonZero && (rs1Hit || rs2Hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard control unit: load-use stalls, multi-cycle EX freeze and taken-branch IF/ID flush.
// Optional perf counters (o_stall_cnt, o_flush_cnt) are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_read,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic              i_mem_read,
  input  logic              i_ex_multi,
  input  logic              i_branch_taken,
  output logic              o_pc_enable,
  output logic              o_if_id_register_enable,
  output logic              o_if_id_flush,
  output logic              o_pipeline_stall,
`ifdef HAZARD_PERF_CNT_EN
  output logic              o_ex_hold,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
`else
  output logic              o_ex_hold
`endif
);

  if (!hz_params_ok(MUL_LAT, LOAD_LAT, CNT_W)) begin : g_bad_params
    $error("hazard_ctrl: MUL_LAT must be 2..16, LOAD_LAT 1..2, CNT_W >= 1");
  end

  localparam logic [HZ_CNT_BITS-1:0] MULTI_LOAD = HZ_CNT_BITS'(MUL_LAT - 1);

  hz_state_e              state_q, state_d;
  logic [HZ_CNT_BITS-1:0] cnt_q, cnt_d;
  hz_out_t                outs;

  logic hitEx;
  logic hitMem;
  logic luEx;
  logic luMem;

  hazard_match #(.REG_AW(REG_AW)) u_match_ex (
    .rd_i       (i_ex_rd),
    .rs1_i      (i_id_rs1),
    .rs2_i      (i_id_rs2),
    .rs1_used_i (i_id_rs1_used),
    .rs2_used_i (i_id_rs2_used),
    .hit_o      (hitEx)
  );

  hazard_match #(.REG_AW(REG_AW)) u_match_mem (
    .rd_i       (i_mem_rd),
    .rs1_i      (i_id_rs1),
    .rs2_i      (i_id_rs2),
    .rs1_used_i (i_id_rs1_used),
    .rs2_used_i (i_id_rs2_used),
    .hit_o      (hitMem)
  );

  assign luEx  = i_ex_read && hitEx;
  // With single-cycle load latency the MEM-stage load already forwards, so it is never a hazard.
  assign luMem = (LOAD_LAT >= 2) ? (i_mem_read && hitMem) : 1'b0;

  always_comb begin
    outs    = HZ_RUN_OUT;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (i_branch_taken) begin
          outs.if_id_flush    = 1'b1;
          outs.pipeline_stall = 1'b0;
        end else if (i_ex_multi) begin
          state_d = S_MULTI;
          cnt_d   = MULTI_LOAD;
        end else if (luEx || luMem) begin
          outs.pc_enable      = 1'b0;
          outs.if_id_enable   = 1'b0;
          outs.pipeline_stall = 1'b0;
        end
      end
      S_MULTI: begin
        outs.pc_enable    = 1'b0;
        outs.if_id_enable = 1'b0;
        outs.ex_hold      = 1'b1;
        cnt_d             = cnt_q - 1'b1;
        if (cnt_q == HZ_CNT_BITS'(1)) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_pc_enable             = outs.pc_enable;
  assign o_if_id_register_enable = outs.if_id_enable;
  assign o_if_id_flush           = outs.if_id_flush;
  assign o_pipeline_stall        = outs.pipeline_stall;
  assign o_ex_hold               = outs.ex_hold;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt_q;
  logic [CNT_W-1:0] flushCnt_q;

  // Counters saturate rather than wrap so a long run never reports a tiny count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (!outs.pc_enable && (stallCnt_q != '1)) begin
        stallCnt_q <= stallCnt_q + 1'b1;
      end
      if (outs.if_id_flush && (flushCnt_q != '1)) begin
        flushCnt_q <= flushCnt_q + 1'b1;
      end
    end
  end

  assign o_stall_cnt = stallCnt_q;
  assign o_flush_cnt = flushCnt_q;
`endif

endmodule
